// File: rtl/phase_comp_reg_bridge_pkg.sv
// Shared definitions for the phase compensator register bridge:
// state encoding, register index sizing and serial frame layout.
package phase_comp_pkg;

  localparam int unsigned NUM_REGS         = 16;
  localparam int unsigned REG_IDX_W        = $clog2(NUM_REGS);
  localparam int unsigned IDLE_REG_DEFAULT = 7;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    WRITE,
    READ_WAIT,
    SHIFT_OUT
  } state_t;

  // Frame is {rw, reg_num, data}; data occupies the LSBs.
  function automatic int unsigned frm_w(input int unsigned data_w);
    return 1 + REG_IDX_W + data_w;
  endfunction

  function automatic int unsigned rw_bit(input int unsigned data_w);
    return REG_IDX_W + data_w;
  endfunction

  function automatic int unsigned num_msb(input int unsigned data_w);
    return REG_IDX_W + data_w - 1;
  endfunction

  function automatic int unsigned num_lsb(input int unsigned data_w);
    return data_w;
  endfunction

endpackage

// File: rtl/phase_comp_shift_reg.sv
// Parameterised shift register with parallel load and a shift counter;
// load also clears the counter.
module phase_comp_shift_reg #(
  parameter int unsigned W     = 8,
  parameter int unsigned CNT_W = $clog2(W + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [W-1:0]     load_val,
  input  logic             shift,
  input  logic             din,
  output logic [W-1:0]     q,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q     <= '0;
      count <= '0;
    end else if (load) begin
      q     <= load_val;
      count <= '0;
    end else if (shift) begin
      q     <= W'({q, din});
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/phase_comp_reg_bridge.sv
// Serial host bridge to the phase compensator register port: collects a
// framed command, then performs one register write or read-and-shift-out.
module phase_comp_reg_bridge
  import phase_comp_pkg::*;
#(
  parameter int unsigned DATA_W    = 2,
  parameter int unsigned READ_LAT  = 1,
  parameter int unsigned WR_CYCLES = 1,
  parameter int unsigned IDLE_REG  = IDLE_REG_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ser_frame,
  input  logic                 ser_din,
  output logic                 ser_dout,
  output logic                 ser_dout_valid,
  output logic [REG_IDX_W-1:0] reg_num,
  output logic                 reg_write_readb,
  output logic [DATA_W-1:0]    reg_load_data,
  input  logic [DATA_W-1:0]    reg_read_data,
  output logic                 busy,
  output logic                 wr_done,
  output logic                 frame_err
);

  localparam int unsigned FRM_W  = frm_w(DATA_W);
  localparam int unsigned RW_BIT = rw_bit(DATA_W);
  localparam int unsigned N_MSB  = num_msb(DATA_W);
  localparam int unsigned N_LSB  = num_lsb(DATA_W);
  localparam int unsigned IN_CW  = $clog2(FRM_W + 1);
  localparam int unsigned OUT_CW = $clog2(DATA_W + 1);

  localparam logic [IN_CW-1:0]  IN_LAST  = IN_CW'(FRM_W - 1);
  localparam logic [OUT_CW-1:0] OUT_LAST = OUT_CW'(DATA_W - 1);
  localparam logic [1:0]        WR_LAST  = 2'(WR_CYCLES - 1);
  localparam logic [1:0]        RD_LAST  = 2'(READ_LAT - 1);

  state_t              state;
  logic                frame_d;
  logic [1:0]          wait_cnt;
  logic                accept;
  logic [FRM_W-1:0]    in_q;
  logic [FRM_W-1:0]    frame_next;
  logic [IN_CW-1:0]    in_cnt;
  logic                in_load;
  logic                in_shift;
  logic [DATA_W-1:0]   out_q;
  logic [OUT_CW-1:0]   out_cnt;
  logic                out_load;
  logic                out_shift;
  logic [DATA_W-1:0]   out_load_val;

  // Only a rising edge of ser_frame starts a frame, so a frame still high
  // when the bridge returns to IDLE is ignored until it drops.
  assign accept     = ser_frame & ~frame_d;
  assign frame_next = FRM_W'({in_q, ser_din});
  assign ser_dout   = 1'(out_q >> (DATA_W - 1));

  phase_comp_shift_reg #(.W(FRM_W), .CNT_W(IN_CW)) u_in_sr (
    .clk(clk), .reset(reset), .load(in_load), .load_val('0),
    .shift(in_shift), .din(ser_din), .q(in_q), .count(in_cnt)
  );

  phase_comp_shift_reg #(.W(DATA_W), .CNT_W(OUT_CW)) u_out_sr (
    .clk(clk), .reset(reset), .load(out_load), .load_val(out_load_val),
    .shift(out_shift), .din(1'b0), .q(out_q), .count(out_cnt)
  );

  always_comb begin
    in_load      = 1'b0;
    in_shift     = 1'b0;
    out_load     = 1'b0;
    out_shift    = 1'b0;
    out_load_val = '0;
    case (state)
      IDLE:      in_shift = accept;
      SHIFT_IN:  if (ser_frame && in_cnt != IN_LAST) in_shift = 1'b1;
                 else in_load = 1'b1;
      READ_WAIT: if (wait_cnt == RD_LAST) begin
                   out_load     = 1'b1;
                   out_load_val = reg_read_data;
                 end
      SHIFT_OUT: if (out_cnt == OUT_LAST) out_load = 1'b1;
                 else out_shift = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      frame_d         <= 1'b1;
      wait_cnt        <= '0;
      reg_num         <= REG_IDX_W'(IDLE_REG);
      reg_write_readb <= 1'b0;
      reg_load_data   <= '0;
      ser_dout_valid  <= 1'b0;
      busy            <= 1'b0;
      wr_done         <= 1'b0;
      frame_err       <= 1'b0;
    end else begin
      frame_d   <= ser_frame;
      wr_done   <= 1'b0;
      frame_err <= (state != IDLE) && accept;
      case (state)
        IDLE: if (accept) begin
          state <= SHIFT_IN;
          busy  <= 1'b1;
        end
        SHIFT_IN: if (!ser_frame) begin
          frame_err <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end else if (in_cnt == IN_LAST) begin
          reg_num  <= frame_next[N_MSB:N_LSB];
          wait_cnt <= '0;
          if (frame_next[RW_BIT]) begin
            reg_write_readb <= 1'b1;
            reg_load_data   <= frame_next[DATA_W-1:0];
            state           <= WRITE;
          end else begin
            state <= READ_WAIT;
          end
        end
        WRITE: if (wait_cnt == WR_LAST) begin
          reg_write_readb <= 1'b0;
          reg_num         <= REG_IDX_W'(IDLE_REG);
          wr_done         <= 1'b1;
          busy            <= 1'b0;
          state           <= IDLE;
        end else begin
          wait_cnt <= wait_cnt + 2'd1;
        end
        READ_WAIT: if (wait_cnt == RD_LAST) begin
          ser_dout_valid <= 1'b1;
          state          <= SHIFT_OUT;
        end else begin
          wait_cnt <= wait_cnt + 2'd1;
        end
        SHIFT_OUT: if (out_cnt == OUT_LAST) begin
          ser_dout_valid <= 1'b0;
          reg_num        <= REG_IDX_W'(IDLE_REG);
          busy           <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_phase_comp_reg_bridge.sv
// Scoreboard bench for phase_comp_reg_bridge (DATA_W=2, READ_LAT=1, WR_CYCLES=1).
module tb_phase_comp_reg_bridge;

  localparam int DATA_W = 2;

  typedef struct packed {
    logic [3:0] num;
    logic [1:0] data;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              ser_frame;
  logic              ser_din;
  logic              ser_dout;
  logic              ser_dout_valid;
  logic [3:0]        reg_num;
  logic              reg_write_readb;
  logic [DATA_W-1:0] reg_load_data;
  logic [DATA_W-1:0] reg_read_data;
  logic              busy;
  logic              wr_done;
  logic              frame_err;

  logic [DATA_W-1:0] rf [16];

  int checks = 0;
  int errors = 0;

  wr_t        exp_wr[$];
  int         exp_done[$];
  logic       exp_bit[$];
  logic [3:0] exp_rsel[$];
  logic       exp_ferr[$];   // expected busy level in the frame_err cycle

  wr_t        mon_w;
  logic       mon_b;
  logic [3:0] mon_n;

  always #5 clk = ~clk;

  assign reg_read_data = rf[reg_num];

  phase_comp_reg_bridge #(
    .DATA_W(2), .READ_LAT(1), .WR_CYCLES(1), .IDLE_REG(7)
  ) dut (
    .clk(clk), .reset(reset), .ser_frame(ser_frame), .ser_din(ser_din),
    .ser_dout(ser_dout), .ser_dout_valid(ser_dout_valid), .reg_num(reg_num),
    .reg_write_readb(reg_write_readb), .reg_load_data(reg_load_data),
    .reg_read_data(reg_read_data), .busy(busy), .wr_done(wr_done),
    .frame_err(frame_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input logic [6:0] f, input int n);
    logic [6:0] bits;
    bits = f;
    for (int i = 0; i < n; i++) begin
      ser_frame = 1'b1;
      ser_din   = bits[6-i];
      tick();
    end
    ser_frame = 1'b0;
    ser_din   = 1'b0;
  endtask

  // Monitor: every DUT-visible event must match the head of its queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (reg_write_readb) begin
        if (exp_wr.size() == 0) check("strobe_unexpected", reg_write_readb, 0);
        else begin
          mon_w = exp_wr.pop_front();
          check("strobe_num", reg_num, mon_w.num);
          check("strobe_data", reg_load_data, mon_w.data);
        end
      end
      if (wr_done) begin
        if (exp_done.size() == 0) check("wr_done_unexpected", wr_done, 0);
        else begin
          void'(exp_done.pop_front());
          check("wr_done_num", reg_num, 7);
          check("wr_done_wrb", reg_write_readb, 0);
        end
      end
      if (ser_dout_valid) begin
        if (exp_bit.size() == 0) check("dout_unexpected", ser_dout_valid, 0);
        else begin
          mon_b = exp_bit.pop_front();
          check("dout_bit", ser_dout, mon_b);
        end
      end
      if (!reg_write_readb && !ser_dout_valid && reg_num != 4'd7) begin
        if (exp_rsel.size() == 0) check("rsel_unexpected", reg_num, 7);
        else begin
          mon_n = exp_rsel.pop_front();
          check("rsel_num", reg_num, mon_n);
        end
      end
      if (frame_err) begin
        if (exp_ferr.size() == 0) check("frame_err_unexpected", frame_err, 0);
        else begin
          mon_b = exp_ferr.pop_front();
          check("frame_err_busy", busy, mon_b);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 2'(i);
    rf[12] = 2'b01;
    rf[3]  = 2'b10;
    reset = 1'b1; ser_frame = 1'b0; ser_din = 1'b0;

    #3;
    check("rst_dout", ser_dout, 0);
    check("rst_valid", ser_dout_valid, 0);
    check("rst_num", reg_num, 7);
    check("rst_wrb", reg_write_readb, 0);
    check("rst_data", reg_load_data, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_done", wr_done, 0);
    check("rst_frame_err", frame_err, 0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    repeat (3) tick();

    // Single write: reg 5 <= 2'b10
    exp_wr.push_back('{num: 4'd5, data: 2'b10});
    exp_done.push_back(1);
    send_frame(7'b1_0101_10, 7);
    check("wr_lat_wrb", reg_write_readb, 1);
    check("wr_lat_num", reg_num, 5);
    check("wr_lat_data", reg_load_data, 2'b10);
    tick();
    check("wr_end_done", wr_done, 1);
    check("wr_end_wrb", reg_write_readb, 0);
    check("wr_end_num", reg_num, 7);
    check("wr_end_busy", busy, 0);
    check("wr_hold_data", reg_load_data, 2'b10);
    tick();
    check("wr_done_pulse", wr_done, 0);
    repeat (2) tick();

    // Read reg 12 (returns 2'b01): bits 0 then 1
    exp_rsel.push_back(4'd12);
    exp_bit.push_back(1'b0);
    exp_bit.push_back(1'b1);
    send_frame(7'b0_1100_11, 7);
    check("rd_sel_num", reg_num, 12);
    check("rd_sel_wrb", reg_write_readb, 0);
    check("rd_sel_valid", ser_dout_valid, 0);
    tick();
    check("rd_bit0_valid", ser_dout_valid, 1);
    check("rd_bit0", ser_dout, 0);
    tick();
    check("rd_bit1_valid", ser_dout_valid, 1);
    check("rd_bit1", ser_dout, 1);
    tick();
    check("rd_end_valid", ser_dout_valid, 0);
    check("rd_end_dout", ser_dout, 0);
    check("rd_end_busy", busy, 0);
    check("rd_end_num", reg_num, 7);
    repeat (2) tick();

    // Short frame: 4 bits then ser_frame low
    exp_ferr.push_back(1'b0);
    send_frame(7'b1010_000, 4);
    tick();
    check("short_err", frame_err, 1);
    check("short_busy", busy, 0);
    tick();
    check("short_err_pulse", frame_err, 0);
    repeat (2) tick();

    // Read reg 3 (2'b10) with a write frame raised during SHIFT_OUT
    exp_rsel.push_back(4'd3);
    exp_bit.push_back(1'b1);
    exp_bit.push_back(1'b0);
    exp_ferr.push_back(1'b1);
    send_frame(7'b0_0011_00, 7);
    tick();
    send_frame(7'b1_0001_11, 7);
    repeat (3) tick();
    check("busy_frame_idle", busy, 0);
    check("busy_frame_hold", reg_load_data, 2'b10);

    // Back-to-back writes with one idle cycle between frames
    exp_wr.push_back('{num: 4'd0, data: 2'b11});
    exp_wr.push_back('{num: 4'd15, data: 2'b01});
    exp_done.push_back(1);
    exp_done.push_back(1);
    send_frame(7'b1_0000_11, 7);
    tick();
    send_frame(7'b1_1111_01, 7);
    check("b2b_second_num", reg_num, 15);
    check("b2b_second_wrb", reg_write_readb, 1);
    repeat (3) tick();

    // Reset during the WRITE cycle
    send_frame(7'b1_1001_01, 7);
    #1 reset = 1'b1;
    #1;
    check("arst_wrb", reg_write_readb, 0);
    check("arst_num", reg_num, 7);
    check("arst_data", reg_load_data, 0);
    check("arst_busy", busy, 0);
    check("arst_done", wr_done, 0);
    check("arst_valid", ser_dout_valid, 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    repeat (4) tick();
    check("arst_no_done", wr_done, 0);

    // Recovery write after reset
    exp_wr.push_back('{num: 4'd9, data: 2'b01});
    exp_done.push_back(1);
    send_frame(7'b1_1001_01, 7);
    repeat (4) tick();

    check("left_wr", exp_wr.size(), 0);
    check("left_done", exp_done.size(), 0);
    check("left_bits", exp_bit.size(), 0);
    check("left_rsel", exp_rsel.size(), 0);
    check("left_ferr", exp_ferr.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/phase_comp_reg_bridge.md
Name: phase_comp_reg_bridge

Overview:
- Serial-to-parallel host bridge that drives the register-access port of the phase compensator control block (the high coarse variant).
- Receives framed serial commands and issues single-register writes (reg_num, reg_write_readb, reg_load_data).
- For reads, captures reg_read_data and shifts it back out serially.
- Sits between the chip-level serial control interface and the phase compensator control block.

Parameters:
- DATA_W, 2: register width. Matches reg_load_data and reg_read_data.
- READ_LAT, 1: cycles reg_num is held before reg_read_data is sampled (1..4).
- WR_CYCLES, 1: cycles reg_write_readb is held high per write (1..4).
- IDLE_REG, 7: reg_num value driven while idle.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ser_frame  in  1  high for the duration of a command frame.
- ser_din  in  1  command bit, sampled when ser_frame=1; MSB first.
- ser_dout  out  1  read data bit, MSB first.
- ser_dout_valid  out  1  ser_dout qualifier.
- reg_num  out  4  target register index.
- reg_write_readb  out  1  1 = write strobe, 0 = read/select.
- reg_load_data  out  DATA_W  write data.
- reg_read_data  in  DATA_W  read data from the control block.
- busy  out  1  high in any state other than IDLE.
- wr_done  out  1  one-cycle pulse after a write completes.
- frame_err  out  1  one-cycle pulse when a frame is rejected.

Behaviour:
- Reset values: ser_dout=0, ser_dout_valid=0, reg_num=IDLE_REG, reg_write_readb=0, reg_load_data=0, busy=0, wr_done=0, frame_err=0, state=IDLE, bit counter=0.
- Reset is asynchronous. If asserted mid-write, reg_write_readb drops immediately, so no partial or extra write occurs after reset.
- Frame format, FRM_W = 5+DATA_W bits: {rw, reg_num[3:0], data[DATA_W-1:0]}. rw=1 is a write; rw=0 is a read, and its data bits are ignored.
- States: IDLE, SHIFT_IN, WRITE, READ_WAIT, SHIFT_OUT.
- IDLE:
  - ser_frame=1 moves to SHIFT_IN, and the bit present in that cycle is captured as bit 0.
- SHIFT_IN:
  - Shift ser_din in on each cycle with ser_frame=1.
  - Counter reaches FRM_W with rw=1: go to WRITE in the next cycle.
  - Counter reaches FRM_W with rw=0: go to READ_WAIT in the next cycle.
  - Bits beyond FRM_W are not possible because the transition occurs on the last bit. Any ser_frame high cycles after that are ignored until ser_frame falls.
  - ser_frame falls before FRM_W bits: discard the frame, pulse frame_err, return to IDLE. No bus activity occurs.
- WRITE:
  - Drive reg_num, reg_load_data and reg_write_readb=1 for exactly WR_CYCLES cycles.
  - Then reg_write_readb=0 and reg_num=IDLE_REG, with wr_done=1 in that same cycle; go to IDLE.
- READ_WAIT:
  - Drive reg_num, reg_write_readb=0 for READ_LAT cycles.
  - Capture reg_read_data on the clock edge ending the last cycle; go to SHIFT_OUT.
- SHIFT_OUT:
  - DATA_W cycles with ser_dout_valid=1, ser_dout = captured data MSB first.
  - Then ser_dout_valid=0, ser_dout=0, reg_num=IDLE_REG; go to IDLE.
- Latency, counted from the cycle holding the last frame bit:
  - Write: strobe starts the next cycle.
  - Read: first ser_dout bit comes READ_LAT+1 cycles later.
- Busy handling:
  - A ser_frame rising edge while busy pulses frame_err once; that frame is ignored entirely.
  - The bridge must see ser_frame low in IDLE before it accepts a new frame.
- Back-to-back frames: a frame starting in the cycle right after return to IDLE is accepted.
- reg_load_data holds its last written value between writes. Only reg_write_readb qualifies it.

Decomposition:
- Shared package phase_comp_pkg holds:
  - the state enum;
  - REG_IDX_W=4 and NUM_REGS=16;
  - the frame field offsets (RW_BIT, NUM_MSB/NUM_LSB);
  - IDLE_REG_DEFAULT=7.
- One sub-module, phase_comp_shift_reg: a parameterised shift register with load/shift/count, used for both the input frame and the output data.

Test Plan (DATA_W=2, READ_LAT=1, WR_CYCLES=1):
- Write frame 1,0101,10 -> next cycle: reg_num=5, reg_load_data=2'b10, reg_write_readb=1 for exactly 1 cycle. The following cycle: wr_done=1, reg_num=7, reg_write_readb=0.
- Read frame 0,1100,xx with reg_read_data=2'b01 returned for reg_num=12 -> reg_num=12, reg_write_readb=0 for 1 cycle. Then ser_dout_valid=1 for 2 cycles with ser_dout 0 then 1; then busy=0.
- Short frame (ser_frame high for 4 bits) -> frame_err pulses once; reg_write_readb stays 0; state returns to IDLE.
- Reset asserted in the WRITE cycle -> reg_write_readb=0 asynchronously, all outputs at reset values, no wr_done.
- New frame raised during SHIFT_OUT -> frame_err pulses once; read data completes unchanged; that frame produces no bus activity.
- Two write frames to reg 0 (2'b11) then reg 15 (2'b01), separated by a single idle cycle -> two strobes with the correct reg_num/data and two wr_done pulses.
